// File: rtl/alu_bitserial_ctrl.sv
// Bit-serial sequencer for a single 1-bit ALU slice: streams operand bits LSB first,
// recirculates carry/borrow for ADD/SUB and assembles the WIDTH-bit result.
module alu_bitserial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_op,
  input  logic             slice_r,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic illegal_s;
  logic arith_s;
  logic running_s;

  assign illegal_s = (op_q[2:1] == 2'b11);
  assign arith_s   = (op_q == 3'b010) || (op_q == 3'b011);
  assign running_s = (state_q == RUN);

  // Slice drive is decoded from registered state only; everything is parked at 0 outside RUN.
  assign slice_a   = running_s ? sa_q[0] : 1'b0;
  assign slice_b   = running_s ? sb_q[0] : 1'b0;
  assign slice_cin = (running_s && arith_s) ? cy_q : 1'b0;
  assign slice_op  = (running_s && !illegal_s) ? op_q : 3'b000;

  assign busy   = running_s;
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          op_d     = op;
          sa_d     = opa;
          sb_d     = opb;
          result_d = {WIDTH{1'b0}};
          cnt_d    = {CW{1'b0}};
          cy_d     = 1'b0;
          carry_d  = 1'b0;
          zero_d   = 1'b0;
          err_d    = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Illegal ops shift in zeros so the result lands at 0 with normal latency.
        result_d = {(slice_r & ~illegal_s), result_q[WIDTH-1:1]};
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        cy_d     = arith_s ? slice_cout : 1'b0;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          carry_d = cy_d;
          zero_d  = (result_d == {WIDTH{1'b0}});
          err_d   = illegal_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 3'b000;
      sa_q     <= {WIDTH{1'b0}};
      sb_q     <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      cy_q     <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

endmodule
